// File: rtl/core_io_bridge.sv
// rtl/core_io_bridge.sv - byte-wide core I/O bridge with transmit and receive FIFOs.
// Optional interrupt via CORE_IO_BRIDGE_INT_EN; the request output is "intr" because "int" is reserved.

module core_io_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
endmodule

module core_io_bridge #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] EMPTY_VALUE = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ioout,
  input  logic       iowr,
  input  logic       iord,
  output logic [7:0] ioin,
  output logic       intr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       tx_overflow
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_head;
  logic          overflow_q;

  core_io_fifo #(.DEPTH(DEPTH), .W(8)) u_tx (
    .clock (clock),
    .reset (reset),
    .push  (iowr),
    .wdata (ioout),
    .pop   (tx_ready),
    .rdata (tx_data),
    .count (tx_count)
  );

  core_io_fifo #(.DEPTH(DEPTH), .W(8)) u_rx (
    .clock (clock),
    .reset (reset),
    .push  (rx_valid && rx_ready),
    .wdata (rx_data),
    .pop   (iord),
    .rdata (rx_head),
    .count (rx_count)
  );

  assign tx_valid = (tx_count != '0);
  assign rx_ready = (rx_count != CW'(DEPTH));
  assign ioin     = (rx_count != '0) ? rx_head : EMPTY_VALUE;

  // A write is lost only when full and the host is not draining this cycle.
  always_ff @(posedge clock) begin
    if (!reset)
      overflow_q <= 1'b0;
    else if (iowr && (tx_count == CW'(DEPTH)) && !tx_ready)
      overflow_q <= 1'b1;
  end
  assign tx_overflow = overflow_q;

`ifdef CORE_IO_BRIDGE_INT_EN
  assign intr = (rx_count != '0);
`else
  assign intr = 1'b0;
`endif
endmodule

// File: tb/tb_core_io_bridge.sv
// tb/tb_core_io_bridge.sv - self-checking bench for core_io_bridge with a queue-based reference model.
module tb_core_io_bridge;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ioout = 8'h00;
  logic       iowr = 1'b0, iord = 1'b0;
  logic [7:0] ioin;
  logic       intr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       tx_overflow;

  int total = 0;
  int bad = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         ovf = 1'b0;

  always #5 clock = ~clock;

  core_io_bridge dut (
    .clock(clock), .reset(reset), .ioout(ioout), .iowr(iowr), .iord(iord),
    .ioin(ioin), .intr(intr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_overflow(tx_overflow)
  );

  // Advance one clock; the model applies the FIFO rules to the inputs present at the edge.
  task automatic cycle();
    bit tpop, rpop, rrdy;
    logic [7:0] junk;
    @(posedge clock);
    if (!reset) begin
      txq.delete();
      rxq.delete();
      ovf = 1'b0;
    end else begin
      tpop = (txq.size() > 0) && tx_ready;
      rrdy = rxq.size() < DEPTH;
      rpop = iord && (rxq.size() > 0);
      if (tpop) junk = txq.pop_front();
      if (iowr) begin
        if (txq.size() < DEPTH) txq.push_back(ioout);
        else ovf = 1'b1;
      end
      if (rpop) junk = rxq.pop_front();
      if (rx_valid && rrdy) rxq.push_back(rx_data);
    end
    #1;
  endtask

  function automatic logic [7:0] exp_ioin();
    return (rxq.size() > 0) ? rxq[0] : 8'h00;
  endfunction

  function automatic logic exp_int();
`ifdef CORE_IO_BRIDGE_INT_EN
    return rxq.size() > 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b0; iowr = 1'b1; ioout = 8'hFF; rx_valid = 1'b1; rx_data = 8'h77;
    cycle(); cycle();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got %0b want 1", rx_ready); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_int got %0b want 0", intr); end
    total++; if (ioin !== 8'h00) begin bad++; $display("FAIL reset_ioin got %0h want 00", ioin); end
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %0b want 0", tx_overflow); end
    reset = 1'b1; iowr = 1'b0; rx_valid = 1'b0;
    cycle();
  endtask

  task automatic test_tx_order();
    tx_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      ioout = 8'(v); iowr = 1'b1;
      cycle();
      if (v == 1) begin
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'd1) begin bad++; $display("FAIL tx_latency got v=%0b d=%0h want v=1 d=01", tx_valid, tx_data); end
      end
    end
    iowr = 1'b0; tx_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin bad++; $display("FAIL tx_order got v=%0b d=%0h want v=1 d=%0h", tx_valid, tx_data, i); end
      cycle();
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got %0b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ioout = 8'hA0 + 8'(i); iowr = 1'b1;
      cycle();
    end
    iowr = 1'b0;
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL tx_overflow_set got %0b want 1", tx_overflow); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL tx_overflow_drain got v=%0b d=%0h want v=1 d=%0h", tx_valid, tx_data, 8'hA0 + i); end
      cycle();
    end
    total++; if (tx_valid !== 1'b0 || tx_overflow !== 1'b1) begin bad++; $display("FAIL tx_overflow_sticky got v=%0b ovf=%0b want v=0 ovf=1", tx_valid, tx_overflow); end
    tx_ready = 1'b0; reset = 1'b0;
    cycle();
    reset = 1'b1;
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_overflow_clear got %0b want 0", tx_overflow); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'd12; cycle();
    rx_data = 8'd233; cycle();
    rx_valid = 1'b0;
    total++; if (ioin !== 8'd12 || intr !== exp_int()) begin bad++; $display("FAIL rx_head got ioin=%0d int=%0b want ioin=12 int=%0b", ioin, intr, exp_int()); end
    iord = 1'b1; cycle(); iord = 1'b0;
    total++; if (ioin !== 8'd233) begin bad++; $display("FAIL rx_second got %0d want 233", ioin); end
    iord = 1'b1; cycle(); iord = 1'b0;
    total++; if (ioin !== 8'h00 || intr !== 1'b0) begin bad++; $display("FAIL rx_empty got ioin=%0h int=%0b want ioin=00 int=0", ioin, intr); end
    iord = 1'b1; cycle(); iord = 1'b0;
    total++; if (ioin !== 8'h00 || rx_ready !== 1'b1) begin bad++; $display("FAIL rx_read_empty got ioin=%0h rdy=%0b want ioin=00 rdy=1", ioin, rx_ready); end
  endtask

  task automatic test_full_concurrency();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioout = 8'h10 + 8'(i); iowr = 1'b1; cycle();
    end
    ioout = 8'h55; tx_ready = 1'b1; cycle();
    iowr = 1'b0;
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL full_push_pop_overflow got %0b want 0", tx_overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_data !== ((i == 3) ? 8'h55 : 8'h11 + 8'(i)) || tx_valid !== 1'b1) begin bad++; $display("FAIL full_push_pop_order got v=%0b d=%0h at %0d", tx_valid, tx_data, i); end
      cycle();
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'h20 + 8'(i); cycle();
    end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready got %0b want 0", rx_ready); end
    rx_data = 8'h99; cycle();
    rx_valid = 1'b0;
    total++; if (rx_ready !== 1'b0 || ioin !== 8'h20) begin bad++; $display("FAIL rx_full_drop got rdy=%0b ioin=%0h want rdy=0 ioin=20", rx_ready, ioin); end
    iord = 1'b1; cycle(); iord = 1'b0;
    total++; if (rx_ready !== 1'b1 || ioin !== 8'h21) begin bad++; $display("FAIL rx_full_pop got rdy=%0b ioin=%0h want rdy=1 ioin=21", rx_ready, ioin); end
    iord = 1'b1; cycle(); cycle(); cycle(); iord = 1'b0;
    total++; if (ioin !== 8'h00) begin bad++; $display("FAIL rx_full_drain got %0h want 00", ioin); end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iowr = 1'b1; ioout = 8'h30 + 8'(i); rx_valid = 1'b1; rx_data = 8'h40 + 8'(i); cycle();
    end
    total++; if (tx_valid !== 1'b1 || ioin !== 8'h40) begin bad++; $display("FAIL mid_queued got v=%0b ioin=%0h want v=1 ioin=40", tx_valid, ioin); end
    reset = 1'b0; cycle();
    reset = 1'b1; iowr = 1'b0; rx_valid = 1'b0;
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || ioin !== 8'h00 || intr !== 1'b0 || tx_overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset got v=%0b rdy=%0b ioin=%0h int=%0b ovf=%0b want 0 1 00 0 0", tx_valid, rx_ready, ioin, intr, tx_overflow);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(63) != 0);
      iowr     = $urandom_range(1);
      ioout    = 8'($urandom);
      tx_ready = ($urandom_range(2) == 0);
      rx_valid = $urandom_range(1);
      rx_data  = 8'($urandom);
      iord     = ($urandom_range(2) == 0);
      cycle();
      total++; if (tx_valid !== (txq.size() > 0)) begin bad++; $display("FAIL rand_tx_valid n=%0d got %0b want %0b", n, tx_valid, txq.size() > 0); end
      if (txq.size() > 0) begin
        total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL rand_tx_data n=%0d got %0h want %0h", n, tx_data, txq[0]); end
      end
      total++; if (rx_ready !== (rxq.size() < DEPTH)) begin bad++; $display("FAIL rand_rx_ready n=%0d got %0b want %0b", n, rx_ready, rxq.size() < DEPTH); end
      total++; if (ioin !== exp_ioin()) begin bad++; $display("FAIL rand_ioin n=%0d got %0h want %0h", n, ioin, exp_ioin()); end
      total++; if (intr !== exp_int()) begin bad++; $display("FAIL rand_int n=%0d got %0b want %0b", n, intr, exp_int()); end
      total++; if (tx_overflow !== ovf) begin bad++; $display("FAIL rand_overflow n=%0d got %0b want %0b", n, tx_overflow, ovf); end
    end
    reset = 1'b1; iowr = 1'b0; rx_valid = 1'b0; iord = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx();
    test_full_concurrency();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_io_bridge.md
# core_io_bridge

Peripheral end of the core's byte-wide I/O port. It buffers bytes the core writes on `ioout` into a transmit FIFO for a host-side consumer. It also buffers host-side bytes into a receive FIFO, presents the head byte on the core's `ioin`, and raises the core's `int` while receive data is pending. It sits beside `core` in the top level, between the core and any off-chip or testbench byte stream.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `EMPTY_VALUE`, 8'h00: byte driven on `ioin` while the receive FIFO is empty.

- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clock`.
- `ioout`  in  8  core write data.
- `iowr`  in  1  core write strobe, one byte per cycle high.
- `iord`  in  1  core read strobe; pops receive head.
- `ioin`  out  8  receive head byte to core.
- `int`  out  1  interrupt request to core.
- `tx_data`  out  8  transmit head byte.
- `tx_valid`  out  1  transmit FIFO non-empty.
- `tx_ready`  in  1  host consumes `tx_data` when high with `tx_valid`.
- `rx_data`  in  8  host byte to core.
- `rx_valid`  in  1  host offers `rx_data`.
- `rx_ready`  out  1  receive FIFO not full.
- `tx_overflow`  out  1  sticky: a core write was dropped.

## Operation
- Two independent circular FIFOs, each with read pointer, write pointer, count (width $clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Reset (`reset`=0 at edge): pointers/counts 0, `tx_overflow`=0. Resulting outputs: `tx_valid`=0, `rx_ready`=1, `int`=0, `ioin`=EMPTY_VALUE, `tx_data`=don't-care. Storage contents not cleared. Reset overrides all strobes in the same cycle, including mid-transfer; in-flight bytes are discarded.
- Transmit FIFO:
  - Push when `iowr`=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Pop when `tx_valid`&&`tx_ready`.
  - Simultaneous push+pop: count unchanged, order preserved.
  - `iowr` while full with no pop: byte dropped, `tx_overflow` set until reset.
- Receive FIFO:
  - `rx_ready` = count<DEPTH, from registered count only, with no dependence on `iord`.
  - Push when `rx_valid`&&`rx_ready`.
  - Pop when `iord`=1 and count>0.
  - `iord` on empty: no state change.
  - Simultaneous push+pop when neither full nor empty: count unchanged.
- `ioin` = receive head when count>0, else EMPTY_VALUE. Combinational from registered state.
- `int`: see Configuration.

## Timing
- All outputs are functions of registered state only; there are no input-to-output combinational paths.
- Core write at edge N: `tx_valid`=1 and `tx_data`=byte after edge N, so the byte is visible in cycle N+1.
- Host push at edge N: `ioin` shows byte and `int`=1 from cycle N+1.
- Core `iord` at edge N: the next byte, or EMPTY_VALUE, appears on `ioin` from cycle N+1. The core samples `ioin` before asserting `iord`.
- Throughput: one byte per cycle per direction, sustained.

## Configuration
- Macro `CORE_IO_BRIDGE_INT_EN`.
- Defined: `int` = (receive count > 0), registered-state derived; deasserts the cycle after the last byte is popped.
- Undefined: `int` tied to 0. Core polls `ioin` against EMPTY_VALUE. All other behaviour identical.

## Test plan
- Reset: hold `reset`=0 two cycles with `iowr`=1, `rx_valid`=1 -> `tx_valid`=0, `rx_ready`=1, `int`=0, `ioin`=8'h00, `tx_overflow`=0.
- Core writes 8'd1, 8'd2, 8'd3 on consecutive cycles, `tx_ready`=0, then `tx_ready`=1 -> `tx_data` sequence 1,2,3, then `tx_valid`=0.
- Five writes 8'hA0..8'hA4 with `tx_ready`=0, DEPTH=4 -> `tx_overflow`=1; drained bytes A0..A3 only.
- Host pushes 8'd12, 8'd233 -> `int`=1 (INT_EN), `ioin`=12; `iord` once -> `ioin`=233; `iord` again -> `ioin`=8'h00, `int`=0.
- Full-FIFO concurrency: tx FIFO full, same cycle `iowr`=1 with 8'h55 and `tx_ready`=1 -> no overflow, 8'h55 drained last. Separately, rx FIFO full -> `rx_ready`=0; `iord` pulse -> `rx_ready`=1 the next cycle.
- Reset mid-stream: 2 bytes queued each side, `reset`=0 one cycle -> both FIFOs empty, `int`=0, `tx_overflow`=0.
